// File: rtl/load_receiver.sv
// Serial program-load receiver: deserialises host frames into imem/dmem
// write strobes and turns run mode into a core start/done handshake.
module load_receiver #(
    parameter int nAddrBits = 4,
    parameter int nDataBits = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode_in,
    input  logic                 mosi_in,
    input  logic                 core_halt_in,
    output logic                 imem_we,
    output logic                 dmem_we,
    output logic [nAddrBits-1:0] waddr,
    output logic [nDataBits-1:0] wdata,
    output logic                 core_start,
    output logic                 done_out,
    output logic                 frame_err,
    output logic [7:0]           frames_rx
);

    localparam int W = nAddrBits + nDataBits;
    localparam logic [4:0] WMIN = 5'(W);

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_IMEM = 2'b01;
    localparam logic [1:0] M_DMEM = 2'b10;
    localparam logic [1:0] M_RUN  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [W-1:0]         sr_q, sr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 imem_we_q, imem_we_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [nAddrBits-1:0] waddr_q, waddr_d;
    logic [nDataBits-1:0] wdata_q, wdata_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [7:0]           frames_q, frames_d;

    logic [W-1:0] sr_shift;
    logic [3:0]   cnt_inc;

    assign sr_shift = {mosi_in, sr_q[W-1:1]};
    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        imem_we_d = 1'b0;
        dmem_we_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        start_d   = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        // a strobe on the output this cycle means one more committed frame
        frames_d  = frames_q + {7'd0, imem_we_q | dmem_we_q};

        unique case (state_q)
            S_IDLE: begin
                if (mode_in == M_IMEM || mode_in == M_DMEM) begin
                    state_d = S_SHIFT;
                    mode_d  = mode_in;
                    sr_d    = sr_shift;
                    cnt_d   = 4'd1;
                end else if (mode_in == M_RUN) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (mode_in == mode_q) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_inc;
                end else if (mode_in == M_IDLE && {1'b0, cnt_q} >= WMIN) begin
                    state_d = S_COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                imem_we_d = (mode_q == M_IMEM);
                dmem_we_d = (mode_q == M_DMEM);
                waddr_d   = sr_q[nAddrBits-1:0];
                wdata_d   = sr_q[W-1:nAddrBits];
                state_d   = S_IDLE;
            end
            S_RUN: begin
                if (mode_in != M_RUN) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (core_halt_in) begin
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= M_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            imem_we_q <= imem_we_d;
            dmem_we_q <= dmem_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            frames_q  <= frames_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign dmem_we    = dmem_we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign core_start = start_q;
    assign done_out   = done_q;
    assign frame_err  = err_q;
    assign frames_rx  = frames_q;

endmodule

// File: doc/load_receiver.md
# load_receiver

Target-side end of the serial program-load link. Deserialises 13-bit-slot frames arriving on `mosi_in` under the host's `mode_in` qualifier and issues single-cycle write strobes into the tiny processor's instruction memory (imem) or register file (dmem). It also converts run mode into a core start pulse and returns a completion level to the host's `done_in`. It sits between the FPGA-demo host link and the core's load ports.

## Interface

**Parameters**
- `nAddrBits`, default 4: frame address field width (16 slots).
- `nDataBits`, default 8: frame data field width.

**Ports**
- `clk`, input, 1: single clock; every register updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mode_in`, input, 2: 00 idle, 01 imem load, 10 dmem load, 11 run.
- `mosi_in`, input, 1: serial data, LSB first.
- `core_halt_in`, input, 1: level from the core meaning program finished.
- `imem_we`, output, 1: one-cycle imem write strobe.
- `dmem_we`, output, 1: one-cycle dmem write strobe.
- `waddr`, output, nAddrBits: write address, valid while a strobe is high.
- `wdata`, output, nDataBits: write data, valid while a strobe is high.
- `core_start`, output, 1: one-cycle pulse on entry to run.
- `done_out`, output, 1: completion level to host.
- `frame_err`, output, 1: sticky short/aborted-frame flag.
- `frames_rx`, output, 8: count of committed frames, wraps at 255→0.

## Operation

- Frame payload width W = nAddrBits + nDataBits (12 by default). Payload order is addr[0..3], then data[0..7]; the host's trailing pad bit falls outside the sampling window.
- Shift register `sr[W-1:0]`: on every edge in SHIFT, `sr <= {mosi_in, sr[W-1:1]}`. Leading preamble samples shift out naturally. At commit, addr = `sr[nAddrBits-1:0]` and data = `sr[W-1:nAddrBits]`.
- Bit counter `bit_cnt`, 4 bits, saturates at 15. It is cleared on SHIFT entry and increments each SHIFT sample.
- States and transitions:
  - **IDLE**: `mode_in`=01 or 10 → SHIFT. Latch the target, take the first sample, set `bit_cnt`=1. `mode_in`=11 → RUN. Pulse `core_start` in the next cycle.
  - **SHIFT**, with `mode_in` equal to the latched mode: sample.
  - **SHIFT**, `mode_in`=00: if `bit_cnt` ≥ W, → COMMIT. Otherwise set `frame_err` and → IDLE with no write.
  - **SHIFT**, `mode_in` is the other load mode or 11: abort, set `frame_err`, → IDLE with no write. The new mode is handled from IDLE on the next edge.
  - **COMMIT**: drive the target strobe, `waddr` and `wdata` for exactly one cycle. Increment `frames_rx`. → IDLE unconditionally, even if `mode_in` is already nonzero; that frame's leading samples are lost by design, because the host always sends ≥2 preamble cycles.
  - **RUN**: while `mode_in`=11, once `core_halt_in` is sampled high, `done_out` rises the next cycle and stays high. `mode_in`≠11 → IDLE and clear `done_out`.
- `frame_err` clears only on reset. A good frame does not clear it.
- Strobes, `core_start` and `done_out` are registered outputs. `waddr`/`wdata` hold their last committed value between strobes.

## Timing

- **Reset values:** all outputs 0, `sr`=0, `bit_cnt`=0, state IDLE. Reset is asynchronous and may assert mid-frame or mid-run; any in-flight frame is discarded and no strobe is emitted.
- **Load latency:** `mode_in`=00 is sampled at edge N in SHIFT → COMMIT at edge N. Strobe, address and data are valid in cycle N+1. `frames_rx` updates at edge N+2.
- **Minimum frame:** W sampled cycles of `mode_in`≠00, then one 00 cycle. Frame-to-frame spacing is ≥2 cycles of 00 (COMMIT, IDLE).
- **Run handshake:** `core_start` is high for the one cycle after the IDLE→RUN edge. `done_out` rises one cycle after `core_halt_in` is first sampled high in RUN. It falls the cycle after `mode_in` leaves 11.
- `core_halt_in` high before RUN entry has no effect until RUN is reached; it is then seen on the first RUN edge.
- `imem_we` and `dmem_we` are never high in the same cycle.

## Test plan

- **imem frame:** mode 01 with samples 0,0 then 1,0,1,0,1,1,0,0,0,1,0,1, then mode 00 → `imem_we`=1 for one cycle, `waddr`=5, `wdata`=0xA3, `dmem_we`=0, `frames_rx`=1.
- **dmem full set:** 16 frames with mode 10, addr k, data 0xF0^k → 16 `dmem_we` pulses with matching addr/data, `frames_rx`=16, `frame_err`=0.
- **Short frame:** mode 01 for 7 samples, then 00 → no strobe, `frame_err`=1 and stays 1 through a following good frame.
- **Abort:** mode 01 for 5 samples, then mode 10 → `frame_err`=1, no strobe. The next complete mode-10 frame commits normally one cycle later than usual.
- **Run:** mode 11 → `core_start` is a one-cycle pulse. `core_halt_in` rises after 20 cycles → `done_out`=1 one cycle later. Mode 00 → `done_out`=0 next cycle.
- **Reset mid-frame:** assert `rst` after 8 samples of mode 01 → all outputs 0 immediately. Release, send a full frame → it commits correctly with `frames_rx`=1.
